flash_slot_writer: RTL
======================

# flash_slot_writer

Sequencer that drives the serial-flash engine (toggle-handshake erase/write interface) to reprogram one firmware slot. It sits between the bootloader's byte-stream source (Ethernet/host receive path) and the flash engine. It erases the slot, packs incoming bytes into 256-byte pages, issues one page write per page, and reports completion, progress and timeout errors.

## Interface
- `NUM_PAGES`, 16'd8192: pages per slot (32 sectors × 64 KB / 256 B); legal range 1..65535.
- `TIMEOUT_CYC`, 32'd2_000_000_000: maximum cycles allowed per flash-engine operation before abort.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins an update when idle, ignored otherwise.
- `slot`  in  8  slot base sector; captured on an accepted `start`.
- `abort`  in  1  pulse; cancels the update at the next safe point.
- `byte_valid`  in  1  stream data valid.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `busy`  out  1  high from accepted `start` until `done` or `error`.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  one-cycle pulse on timeout or abort.
- `pages_written`  out  16  pages committed in the current update.
- `erase_req`  out  1  toggle; requests a slot erase.
- `write_req`  out  1  toggle; requests a page write.
- `page_addr`  out  16  flash page address, {sector, page-in-sector}.
- `wr_data`  out  2048  page data; first received byte in [2047:2040].
- `erase_done`  in  1  toggle from the engine.
- `wr_done`  in  1  toggle from the engine.

## Operation
- States: IDLE, ERASE, FILL, WRITE, FINISH.
- IDLE: `busy`=0. On `start`: `page_addr`<={slot,8'h00}, `pages_written`<=0, byte count<=0, toggle `erase_req`, go to ERASE.
- ERASE: wait until `erase_done` differs from the local copy. Then update the copy and go to FILL.
- FILL: `byte_ready`=1. Each handshake (`byte_valid`&&`byte_ready`) shifts `byte_data` into `wr_data` from the top byte down and increments the 8-bit byte count. On the 256th byte: count wraps to 0, toggle `write_req`, go to WRITE.
- WRITE: `byte_ready`=0 and `wr_data`/`page_addr` are held stable. On a `wr_done` toggle: `pages_written`++. If it now equals NUM_PAGES, go to FINISH. Otherwise `page_addr`++ and go to FILL.
- FINISH: pulse `done` for one cycle, go to IDLE.
- Timeout: a 32-bit counter clears on entry to ERASE and WRITE and increments every cycle in those states. Reaching TIMEOUT_CYC pulses `error` and returns to IDLE. No req toggle is issued.
- Abort in FILL: takes effect immediately (`error` pulse, IDLE). In ERASE or WRITE: latched and honoured when the pending done toggle arrives. The engine operation is never interrupted.
- `start` while busy: ignored. `abort` while idle: ignored. `start`+`abort` in the same idle cycle: `start` wins and the abort is dropped.
- `page_addr` increments as 16 bits. Wrap past 16'hFFFF is legal but outside supported slot placement.

## Timing
- Reset values: `erase_req`=0, `write_req`=0, `page_addr`=0, `wr_data`=0, `pages_written`=0, `byte_ready`=0, `busy`=0, `done`=0, `error`=0. State is IDLE.
- Done-copy registers load from `erase_done`/`wr_done` on the first clock after reset release, so stale engine toggle levels never read as completion.
- `start` → `erase_req` toggle and `busy`=1: next edge.
- Done toggle → next state: one cycle. `byte_ready` asserts the cycle after entering FILL.
- 256th accepted byte → `write_req` toggle on the same edge. The engine sees a stable `wr_data` from then until `wr_done`.
- Final `wr_done` → `done` pulse: 2 cycles (WRITE→FINISH→IDLE). `busy` falls with the pulse.

## Configuration
- `FLASH_SKIP_BLANK_EN` defined: FILL tracks whether all 256 bytes equal 8'hFF. A blank page is counted and advanced without toggling `write_req`: `pages_written`++ one cycle after the last byte.
- Undefined: every page is written.

## Test plan
- NUM_PAGES=2, `slot`=8'h20, 512 bytes 0x00..0xFF twice, engine model acks after 10 cycles. Required response: one `erase_req` toggle; two `write_req` toggles with `page_addr`=16'h2000 then 16'h2001; `wr_data`[2047:2040]=8'h00 and [7:0]=8'hFF; `done` pulse; `pages_written`=2.
- Engine never toggles `erase_done`, TIMEOUT_CYC=100. Required response: `error` pulse exactly 100 cycles after ERASE entry; `busy`=0; no `write_req` toggle.
- `abort` mid-FILL after 37 bytes. Required response: `error` next cycle, `byte_ready`=0. A subsequent `start` erases again from page {slot,00}.
- `abort` during WRITE. Required response: no `error` until `wr_done` toggles; `error` pulses one cycle after that; `pages_written` includes that page.
- Reset asserted mid-WRITE with `wr_done`=1, then released. Required response: all outputs return to reset values; the block does not leave IDLE with no `start`.
- With `FLASH_SKIP_BLANK_EN`, NUM_PAGES=2, first page all 0xFF. Required response: single `write_req` toggle, at `page_addr`=base+1; `pages_written`=2; `done`.

Source files
------------

// File: rtl/flash_slot_writer.sv
// Erases one firmware slot, packs the byte stream into 256-byte pages and writes each page via the
// toggle-handshake flash engine. Define FLASH_SKIP_BLANK_EN to skip the write for all-0xFF pages.
module flash_slot_writer #(
    parameter logic [15:0] NUM_PAGES   = 16'd8192,
    parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000_000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    slot,
    input  logic          abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   pages_written,
    output logic          erase_req,
    output logic          write_req,
    output logic [15:0]   page_addr,
    output logic [2047:0] wr_data,
    input  logic          erase_done,
    input  logic          wr_done
);

    // state  | meaning
    // IDLE   | waiting for start; done-copies track the engine levels
    // ERASE  | slot erase requested, waiting for erase_done toggle
    // FILL   | accepting stream bytes into the page buffer
    // WRITE  | page write requested, buffer frozen until wr_done toggle
    // FINISH | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_FILL, S_WRITE, S_FINISH} state_t;

    state_t          state_q, state_d;
    logic            erase_req_q, erase_req_d;
    logic            write_req_q, write_req_d;
    logic [15:0]     page_addr_q, page_addr_d;
    logic [2047:0]   wr_data_q, wr_data_d;
    logic [15:0]     pages_written_q, pages_written_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            erase_cp_q, erase_cp_d;
    logic            wr_cp_q, wr_cp_d;
    logic            abort_pend_q, abort_pend_d;
    logic [31:0]     timer_q, timer_d;
`ifdef FLASH_SKIP_BLANK_EN
    logic            blank_q, blank_d;
`endif

    logic erase_tgl, wr_tgl, abort_now;

    always_comb begin
        state_d         = state_q;
        erase_req_d     = erase_req_q;
        write_req_d     = write_req_q;
        page_addr_d     = page_addr_q;
        wr_data_d       = wr_data_q;
        pages_written_d = pages_written_q;
        byte_cnt_d      = byte_cnt_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        error_d         = 1'b0;
        erase_cp_d      = erase_cp_q;
        wr_cp_d         = wr_cp_q;
        abort_pend_d    = abort_pend_q;
        timer_d         = '0;
`ifdef FLASH_SKIP_BLANK_EN
        blank_d         = blank_q;
`endif
        erase_tgl = (erase_done != erase_cp_q);
        wr_tgl    = (wr_done != wr_cp_q);
        abort_now = abort_pend_q | abort;

        case (state_q)
            S_IDLE: begin
                // Following the engine levels here keeps stale toggles from reading as completion.
                erase_cp_d = erase_done;
                wr_cp_d    = wr_done;
                if (start) begin
                    page_addr_d     = {slot, 8'h00};
                    pages_written_d = '0;
                    byte_cnt_d      = '0;
                    erase_req_d     = ~erase_req_q;
                    busy_d          = 1'b1;
                    abort_pend_d    = 1'b0;
                    state_d         = S_ERASE;
                end
            end
            S_ERASE: begin
                timer_d = timer_q + 32'd1;
                if (abort) abort_pend_d = 1'b1;
                if (erase_tgl) begin
                    erase_cp_d = erase_done;
                    timer_d    = '0;
                    if (abort_now) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else if (timer_d == TIMEOUT_CYC) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (abort) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (byte_valid) begin
                    wr_data_d  = {wr_data_q[2039:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 8'd1;
`ifdef FLASH_SKIP_BLANK_EN
                    blank_d = ((byte_cnt_q == 8'd0) ? 1'b1 : blank_q) & (byte_data == 8'hFF);
                    if (byte_cnt_q == 8'hFF) begin
                        if (blank_d) begin
                            pages_written_d = pages_written_q + 16'd1;
                            if (pages_written_d == NUM_PAGES) begin
                                state_d = S_FINISH;
                            end else begin
                                page_addr_d = page_addr_q + 16'd1;
                            end
                        end else begin
                            write_req_d = ~write_req_q;
                            state_d     = S_WRITE;
                        end
                    end
`else
                    if (byte_cnt_q == 8'hFF) begin
                        write_req_d = ~write_req_q;
                        state_d     = S_WRITE;
                    end
`endif
                end
            end
            S_WRITE: begin
                timer_d = timer_q + 32'd1;
                if (abort) abort_pend_d = 1'b1;
                if (wr_tgl) begin
                    wr_cp_d         = wr_done;
                    timer_d         = '0;
                    pages_written_d = pages_written_q + 16'd1;
                    if (abort_now) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (pages_written_d == NUM_PAGES) begin
                        state_d = S_FINISH;
                    end else begin
                        page_addr_d = page_addr_q + 16'd1;
                        state_d     = S_FILL;
                    end
                end else if (timer_d == TIMEOUT_CYC) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            erase_req_q     <= 1'b0;
            write_req_q     <= 1'b0;
            page_addr_q     <= '0;
            wr_data_q       <= '0;
            pages_written_q <= '0;
            byte_cnt_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            erase_cp_q      <= 1'b0;
            wr_cp_q         <= 1'b0;
            abort_pend_q    <= 1'b0;
            timer_q         <= '0;
`ifdef FLASH_SKIP_BLANK_EN
            blank_q         <= 1'b1;
`endif
        end else begin
            state_q         <= state_d;
            erase_req_q     <= erase_req_d;
            write_req_q     <= write_req_d;
            page_addr_q     <= page_addr_d;
            wr_data_q       <= wr_data_d;
            pages_written_q <= pages_written_d;
            byte_cnt_q      <= byte_cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            erase_cp_q      <= erase_cp_d;
            wr_cp_q         <= wr_cp_d;
            abort_pend_q    <= abort_pend_d;
            timer_q         <= timer_d;
`ifdef FLASH_SKIP_BLANK_EN
            blank_q         <= blank_d;
`endif
        end
    end

    assign byte_ready    = (state_q == S_FILL);
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign pages_written = pages_written_q;
    assign erase_req     = erase_req_q;
    assign write_req     = write_req_q;
    assign page_addr     = page_addr_q;
    assign wr_data       = wr_data_q;

endmodule
